// File: rtl/jukebox_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jukebox_pkg
// Purpose  : Shared types and constants for the jukebox flash sample path.
//            Holds the flash_sample_reader state encoding, the default
//            flash address/data widths and the all-lanes byte-enable value.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package jukebox_pkg;

    // Default flash geometry: 23-bit word address, 32-bit data word.
    localparam int ADDR_W_DEF = 23;
    localparam int DATA_W_DEF = 32;

    // Every flash read fetches the full 32-bit word.
    localparam logic [3:0] BYTEENABLE_ALL = 4'hF;

    // Reader sequencing states.
    typedef enum logic [2:0] {
        FSR_IDLE       = 3'd0,
        FSR_REQ        = 3'd1,
        FSR_WAIT_DATA  = 3'd2,
        FSR_OUT_FIRST  = 3'd3,
        FSR_OUT_SECOND = 3'd4,
        FSR_NEXT       = 3'd5,
        FSR_DONE       = 3'd6
    } fsr_state_t;

endpackage
`default_nettype wire

// File: rtl/flash_sample_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : flash_sample_reader_if
// Purpose  : Bundles the Avalon-MM flash read bus and the audio sample
//            valid/ready stream driven by flash_sample_reader.
// Signals  : flash_address/flash_read/flash_byteenable  master -> flash
//            flash_waitrequest/readdata/readdatavalid     flash  -> master
//            sample_data/sample_valid                     master -> codec
//            sample_ready                                 codec  -> master
// Modports : master (reader side), slave (flash + codec side)
// Revision : 1.0 - initial release
// ============================================================================
interface flash_sample_reader_if
    import jukebox_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic [ADDR_W-1:0]          flash_address;
    logic                       flash_read;
    logic [3:0]                 flash_byteenable;
    logic                       flash_waitrequest;
    logic [DATA_W-1:0]          flash_readdata;
    logic                       flash_readdatavalid;

    logic signed [DATA_W/2-1:0] sample_data;
    logic                       sample_valid;
    logic                       sample_ready;

    modport master (
        output flash_address,
        output flash_read,
        output flash_byteenable,
        input  flash_waitrequest,
        input  flash_readdata,
        input  flash_readdatavalid,
        output sample_data,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  flash_address,
        input  flash_read,
        input  flash_byteenable,
        output flash_waitrequest,
        output flash_readdata,
        output flash_readdatavalid,
        input  sample_data,
        input  sample_valid,
        output sample_ready
    );

endinterface
`default_nettype wire

// File: rtl/flash_sample_reader.sv
`default_nettype none
// ============================================================================
// Module   : flash_sample_reader
// Purpose  : Avalon-MM read master that walks an inclusive word-address range
//            of the song flash, forward or reverse, and splits each 32-bit
//            word into two signed 16-bit samples for the audio output stage.
// Ports    : clk, rst_n              clock, async active-low reset
//            start                   one-cycle pulse, latches range/direction
//            direction               0 = start->end, 1 = end->start
//            pause                   level, holds off new flash reads
//            start_addr, end_addr    inclusive word range
//            busy, done              status / one-cycle end-of-range pulse
//            bus (master modport)    flash read bus + sample stream
// Revision : 1.0 - initial release
// ============================================================================
module flash_sample_reader
    import jukebox_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int LOOP   = 0
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              start,
    input  wire logic              direction,
    input  wire logic              pause,
    input  wire logic [ADDR_W-1:0] start_addr,
    input  wire logic [ADDR_W-1:0] end_addr,
    output logic                   busy,
    output logic                   done,
    flash_sample_reader_if.master  bus
);

    localparam int                SAMPLE_W = DATA_W / 2;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    fsr_state_t                 r_state;
    logic [ADDR_W-1:0]          r_lo_addr;
    logic [ADDR_W-1:0]          r_hi_addr;
    logic [ADDR_W-1:0]          r_cur_addr;
    logic                       r_dir;
    logic [DATA_W-1:0]          r_word;

    logic [ADDR_W-1:0]          r_flash_address;
    logic                       r_flash_read;
    logic signed [SAMPLE_W-1:0] r_sample_data;
    logic                       r_sample_valid;
    logic                       r_busy;
    logic                       r_done;

    logic                       w_terminal;
    logic [ADDR_W-1:0]          w_first_addr;
    logic [ADDR_W-1:0]          w_step_addr;
    logic [ADDR_W-1:0]          w_next_addr;
    logic                       w_take;
    logic [SAMPLE_W-1:0]        w_rd_lo;
    logic [SAMPLE_W-1:0]        w_rd_hi;
    logic [SAMPLE_W-1:0]        w_word_lo;
    logic [SAMPLE_W-1:0]        w_word_hi;

    // Terminal word is the far end of the range in the walking direction.
    assign w_terminal   = r_dir ? (r_cur_addr == r_lo_addr) : (r_cur_addr == r_hi_addr);
    assign w_first_addr = r_dir ? r_hi_addr : r_lo_addr;
    assign w_step_addr  = r_dir ? (r_cur_addr - ADDR_ONE) : (r_cur_addr + ADDR_ONE);
    // In looping mode the terminal word is followed by the first word again.
    assign w_next_addr  = w_terminal ? w_first_addr : w_step_addr;

    assign w_take    = r_sample_valid & bus.sample_ready;
    assign w_rd_lo   = bus.flash_readdata[SAMPLE_W-1:0];
    assign w_rd_hi   = bus.flash_readdata[DATA_W-1:SAMPLE_W];
    assign w_word_lo = r_word[SAMPLE_W-1:0];
    assign w_word_hi = r_word[DATA_W-1:SAMPLE_W];

    assign bus.flash_address    = r_flash_address;
    assign bus.flash_read       = r_flash_read;
    assign bus.flash_byteenable = BYTEENABLE_ALL;
    assign bus.sample_data      = r_sample_data;
    assign bus.sample_valid     = r_sample_valid;
    assign busy                 = r_busy;
    assign done                 = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= FSR_IDLE;
            r_lo_addr       <= '0;
            r_hi_addr       <= '0;
            r_cur_addr      <= '0;
            r_dir           <= 1'b0;
            r_word          <= '0;
            r_flash_address <= '0;
            r_flash_read    <= 1'b0;
            r_sample_data   <= '0;
            r_sample_valid  <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            case (r_state)
                FSR_IDLE: begin
                    if (start) begin
                        r_lo_addr <= start_addr;
                        r_hi_addr <= end_addr;
                        r_dir     <= direction;
                        r_busy    <= 1'b1;
                        if (start_addr > end_addr) begin
                            // Empty range: finish without touching the flash.
                            r_state <= FSR_DONE;
                        end else begin
                            r_cur_addr      <= direction ? end_addr : start_addr;
                            r_flash_address <= direction ? end_addr : start_addr;
                            r_flash_read    <= 1'b1;
                            r_state         <= FSR_REQ;
                        end
                    end
                end

                FSR_REQ: begin
                    // Address and read stay put until the slave stops stalling.
                    if (!bus.flash_waitrequest) begin
                        r_flash_read <= 1'b0;
                        r_state      <= FSR_WAIT_DATA;
                    end
                end

                FSR_WAIT_DATA: begin
                    if (bus.flash_readdatavalid) begin
                        r_word         <= bus.flash_readdata;
                        // Reverse playback emits the upper half first so the
                        // sample order is the exact mirror of forward play.
                        r_sample_data  <= r_dir ? w_rd_hi : w_rd_lo;
                        r_sample_valid <= 1'b1;
                        r_state        <= FSR_OUT_FIRST;
                    end
                end

                FSR_OUT_FIRST: begin
                    if (w_take) begin
                        r_sample_data <= r_dir ? w_word_lo : w_word_hi;
                        r_state       <= FSR_OUT_SECOND;
                    end
                end

                FSR_OUT_SECOND: begin
                    if (w_take) begin
                        r_sample_valid <= 1'b0;
                        r_state        <= FSR_NEXT;
                    end
                end

                FSR_NEXT: begin
                    // The address only moves when the next read is issued, so
                    // waiting here under pause never skips a word.
                    if (w_terminal && (LOOP == 0)) begin
                        r_done  <= 1'b1;
                        r_state <= FSR_DONE;
                    end else if (!pause) begin
                        r_cur_addr      <= w_next_addr;
                        r_flash_address <= w_next_addr;
                        r_flash_read    <= 1'b1;
                        r_state         <= FSR_REQ;
                    end
                end

                FSR_DONE: begin
                    // Entered with done already raised after a normal walk;
                    // an empty range arrives with done low and raises it here.
                    if (!r_done) begin
                        r_done <= 1'b1;
                    end else begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= FSR_IDLE;
                    end
                end

                default: begin
                    r_flash_read   <= 1'b0;
                    r_sample_valid <= 1'b0;
                    r_busy         <= 1'b0;
                    r_done         <= 1'b0;
                    r_state        <= FSR_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flash_sample_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_flash_sample_reader
// Purpose  : Self-checking bench for flash_sample_reader. A flash slave model
//            with programmable stall and latency plus a sample consumer log
//            every accepted read address and sample; a range-level model
//            builds the expected address and sample lists.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flash_sample_reader;
    import jukebox_pkg::*;

    localparam int AW = 23;
    localparam int DW = 32;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          direction = 1'b0;
    logic          pause = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] end_addr = '0;
    logic          busy;
    logic          done;

    logic          startl = 1'b0;
    logic          busyl;
    logic          donel;

    always #5 clk = ~clk;

    flash_sample_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    flash_sample_reader_if #(.ADDR_W(AW), .DATA_W(DW)) busl ();

    flash_sample_reader #(.ADDR_W(AW), .DATA_W(DW), .LOOP(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .direction(direction),
        .pause(pause), .start_addr(start_addr), .end_addr(end_addr),
        .busy(busy), .done(done), .bus(bus)
    );

    flash_sample_reader #(.ADDR_W(AW), .DATA_W(DW), .LOOP(1)) dut_loop (
        .clk(clk), .rst_n(rst_n), .start(startl), .direction(1'b0),
        .pause(1'b0), .start_addr(23'h50), .end_addr(23'h51),
        .busy(busyl), .done(donel), .bus(busl)
    );

    // ---------------- flash contents, shared by both slaves ----------------
    logic [DW-1:0] mem [0:255];

    // ---------------- flash slave model for the main DUT -------------------
    int            wait_cycles = 0;
    int            lat_cycles  = 1;
    logic [AW-1:0] addr_q [$];
    int            ws_cnt, lat_cnt;
    logic [AW-1:0] pend_addr, stall_addr;
    logic          just_acc, prev_stall;
    int            stall_viol = 0, drop_viol = 0, overlap_viol = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            bus.flash_waitrequest   = 1'b0;
            bus.flash_readdatavalid = 1'b0;
            bus.flash_readdata      = '0;
            ws_cnt = 0; lat_cnt = 0; just_acc = 1'b0; prev_stall = 1'b0;
        end else begin
            bus.flash_readdatavalid = 1'b0;
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    bus.flash_readdatavalid = 1'b1;
                    bus.flash_readdata      = mem[pend_addr[7:0]];
                end
            end
            if (just_acc && bus.flash_read) drop_viol++;
            if (prev_stall && (!bus.flash_read || bus.flash_address != stall_addr)) stall_viol++;
            just_acc = 1'b0; prev_stall = 1'b0;
            if (bus.flash_read) begin
                if (ws_cnt < wait_cycles) begin
                    bus.flash_waitrequest = 1'b1;
                    ws_cnt++;
                    prev_stall = 1'b1;
                    stall_addr = bus.flash_address;
                end else begin
                    bus.flash_waitrequest = 1'b0;
                    ws_cnt = 0;
                    just_acc = 1'b1;
                    if (lat_cnt > 0 || bus.flash_readdatavalid) overlap_viol++;
                    lat_cnt   = lat_cycles;
                    pend_addr = bus.flash_address;
                    addr_q.push_back(bus.flash_address);
                end
            end else begin
                bus.flash_waitrequest = 1'b0;
            end
        end
    end

    // ---------------- sample consumer for the main DUT ---------------------
    int            ready_mode = 0;   // 0 always ready, 1 random, 2 never
    logic [SW-1:0] samp_q [$];
    int            hold_viol = 0;
    int            done_cnt  = 0;
    logic          prev_pend;
    logic [SW-1:0] prev_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            bus.sample_ready = 1'b0;
            prev_pend = 1'b0;
        end else begin
            if (prev_pend && (!bus.sample_valid || bus.sample_data != prev_data)) hold_viol++;
            case (ready_mode)
                0:       bus.sample_ready = 1'b1;
                1:       bus.sample_ready = 1'($urandom_range(0, 1));
                default: bus.sample_ready = 1'b0;
            endcase
            if (bus.sample_valid && bus.sample_ready) samp_q.push_back(bus.sample_data);
            prev_pend = bus.sample_valid && !bus.sample_ready;
            prev_data = bus.sample_data;
            if (done) done_cnt++;
        end
    end

    // ---------------- simple slave + consumer for the looping DUT ----------
    logic          pend_l;
    logic [AW-1:0] pa_l;
    logic [AW-1:0] addr_ql [$];
    int            done_l = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            busl.flash_waitrequest   = 1'b0;
            busl.flash_readdatavalid = 1'b0;
            busl.flash_readdata      = '0;
            busl.sample_ready        = 1'b0;
            pend_l = 1'b0;
        end else begin
            busl.sample_ready        = 1'b1;
            busl.flash_readdatavalid = 1'b0;
            if (pend_l) begin
                busl.flash_readdatavalid = 1'b1;
                busl.flash_readdata      = mem[pa_l[7:0]];
                pend_l = 1'b0;
            end
            if (busl.flash_read) begin
                pend_l = 1'b1;
                pa_l   = busl.flash_address;
                addr_ql.push_back(busl.flash_address);
            end
            if (donel) done_l++;
        end
    end

    // ---------------- checking helpers ---------------------------------------
    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Range-level model: every word from the first to the last address in
    // walking order, each yielding low-then-high (forward) or high-then-low
    // (reverse) halves.
    logic [AW-1:0] exp_a [$];
    logic [SW-1:0] exp_s [$];

    task automatic model(input logic [AW-1:0] s, input logic [AW-1:0] e, input logic dir);
        logic [AW-1:0] a;
        logic [DW-1:0] w;
        exp_a.delete();
        exp_s.delete();
        if (s <= e) begin
            for (int i = 0; i <= int'(e - s); i++) begin
                a = dir ? (e - AW'(i)) : (s + AW'(i));
                w = mem[a[7:0]];
                exp_a.push_back(a);
                if (dir) begin
                    exp_s.push_back(w[31:16]);
                    exp_s.push_back(w[15:0]);
                end else begin
                    exp_s.push_back(w[15:0]);
                    exp_s.push_back(w[31:16]);
                end
            end
        end
    endtask

    // Start one range, optionally fire a stray start while busy, wait for the
    // end and compare everything the slave and consumer logged.
    task automatic run_range(input string tag, input logic [AW-1:0] s, input logic [AW-1:0] e,
                             input logic dir, input int junk_at, output int a0, output int s0);
        int   d0, h0, p0;
        logic timed_out;
        a0 = addr_q.size(); s0 = samp_q.size(); d0 = done_cnt; h0 = hold_viol;
        p0 = stall_viol + drop_viol + overlap_viol;
        model(s, e, dir);
        start_addr = s; end_addr = e; direction = dir; start = 1'b1;
        tick();
        start = 1'b0;
        start_addr = AW'($urandom_range(0, 255));
        end_addr   = AW'($urandom_range(0, 255));
        direction  = ~dir;
        timed_out  = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
            if (cyc == junk_at) begin
                start_addr = 23'h70; end_addr = 23'h72; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        chk({tag, "_timeout"}, 64'(timed_out), 64'd0);
        chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        tick();
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
        chk({tag, "_nreads"}, 64'(addr_q.size() - a0), 64'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && a0 + i < addr_q.size(); i++)
            chk($sformatf("%s_addr%0d", tag, i), 64'(addr_q[a0 + i]), 64'(exp_a[i]));
        chk({tag, "_nsamples"}, 64'(samp_q.size() - s0), 64'(exp_s.size()));
        for (int i = 0; i < exp_s.size() && s0 + i < samp_q.size(); i++)
            chk($sformatf("%s_samp%0d", tag, i), 64'(samp_q[s0 + i]), 64'(exp_s[i]));
        chk({tag, "_bus_protocol"}, 64'(stall_viol + drop_viol + overlap_viol - p0), 64'd0);
        chk({tag, "_sample_hold"}, 64'(hold_viol - h0), 64'd0);
    endtask

    // ---------------- vector table -------------------------------------------
    typedef struct {
        logic [AW-1:0] s;
        logic [AW-1:0] e;
        logic          dir;
        int            ws;
        int            lat;
        int            rmode;
        int            junk;
        int            exp_reads;
        logic [AW-1:0] exp_first;
        logic [SW-1:0] exp_samp;
    } vec_t;

    vec_t          vecs [6];
    int            a0, s0, cnt;
    logic [SW-1:0] held;
    logic [AW-1:0] rs;
    logic          ok;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[8'h10] = 32'hAAAA_5555;
        mem[8'h11] = 32'h1234_5678;
        mem[8'h12] = 32'hDEAD_BEEF;
        mem[8'h30] = 32'h0BAD_F00D;
        mem[8'h65] = 32'hCAFE_1234;

        //          s       e       dir   ws lat rm junk reads first   samp
        vecs[0] = '{23'h10, 23'h12, 1'b0, 0, 1, 0, -1, 3, 23'h10, 16'h5555};
        vecs[1] = '{23'h10, 23'h12, 1'b1, 0, 1, 0, -1, 3, 23'h12, 16'hDEAD};
        vecs[2] = '{23'h10, 23'h12, 1'b0, 4, 3, 0, -1, 3, 23'h10, 16'h5555};
        vecs[3] = '{23'h30, 23'h30, 1'b1, 2, 2, 1, -1, 1, 23'h30, 16'h0BAD};
        vecs[4] = '{23'h20, 23'h1F, 1'b0, 0, 1, 0, -1, 0, 23'h00, 16'h0000};
        vecs[5] = '{23'h60, 23'h65, 1'b1, 1, 1, 1,  8, 6, 23'h65, 16'hCAFE};

        // ---- reset state ----
        repeat (3) tick();
        chk("rst_flash_read", 64'(bus.flash_read), 64'd0);
        chk("rst_flash_address", 64'(bus.flash_address), 64'd0);
        chk("rst_sample_valid", 64'(bus.sample_valid), 64'd0);
        chk("rst_sample_data", 64'(bus.sample_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("byteenable", 64'(bus.flash_byteenable), 64'hF);
        rst_n = 1'b1;
        tick();

        // ---- table-driven ranges ----
        for (int v = 0; v < 6; v++) begin
            wait_cycles = vecs[v].ws;
            lat_cycles  = vecs[v].lat;
            ready_mode  = vecs[v].rmode;
            run_range($sformatf("vec%0d", v), vecs[v].s, vecs[v].e, vecs[v].dir,
                      vecs[v].junk, a0, s0);
            chk($sformatf("vec%0d_table_reads", v), 64'(addr_q.size() - a0), 64'(vecs[v].exp_reads));
            if (vecs[v].exp_reads > 0 && addr_q.size() > a0 && samp_q.size() > s0) begin
                chk($sformatf("vec%0d_first_addr", v), 64'(addr_q[a0]), 64'(vecs[v].exp_first));
                chk($sformatf("vec%0d_first_samp", v), 64'(samp_q[s0]), 64'(vecs[v].exp_samp));
            end
        end

        // ---- randomized ranges ----
        for (int r = 0; r < 10; r++) begin
            rs          = AW'($urandom_range(0, 112));
            wait_cycles = $urandom_range(0, 3);
            lat_cycles  = $urandom_range(1, 3);
            ready_mode  = 1;
            run_range($sformatf("rnd%0d", r), rs, rs + AW'($urandom_range(0, 4)),
                      1'($urandom_range(0, 1)), -1, a0, s0);
        end

        // ---- empty range: done two cycles after start, no reads ----
        wait_cycles = 0; lat_cycles = 1; ready_mode = 0;
        a0 = addr_q.size();
        start_addr = 23'h20; end_addr = 23'h1F; direction = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("empty_busy_c1", 64'(busy), 64'd1);
        chk("empty_done_c1", 64'(done), 64'd0);
        tick();
        chk("empty_done_c2", 64'(done), 64'd1);
        tick();
        chk("empty_done_c3", 64'(done), 64'd0);
        chk("empty_busy_c3", 64'(busy), 64'd0);
        chk("empty_reads", 64'(addr_q.size() - a0), 64'd0);

        // ---- backpressure then pause in the middle of a range ----
        ready_mode = 2;
        a0 = addr_q.size(); s0 = samp_q.size();
        model(23'h40, 23'h44, 1'b0);
        start_addr = 23'h40; end_addr = 23'h44; direction = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (bus.sample_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("pause_first_valid", 64'(ok), 64'd1);
        held = bus.sample_data;
        chk("pause_first_data", 64'(held), 64'(mem[8'h40][15:0]));
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (!bus.sample_valid || bus.sample_data != held) cnt++;
        end
        chk("ready_low_hold", 64'(cnt), 64'd0);
        pause = 1'b1; ready_mode = 0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.flash_read) cnt++;
        end
        chk("pause_no_read", 64'(cnt), 64'd0);
        chk("pause_both_taken", 64'(samp_q.size() - s0), 64'd2);
        pause = 1'b0;
        tick();
        chk("resume_read", 64'(bus.flash_read), 64'd1);
        chk("resume_addr", 64'(bus.flash_address), 64'h41);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("pause_range_end", 64'(ok), 64'd1);
        chk("pause_nreads", 64'(addr_q.size() - a0), 64'(exp_a.size()));
        for (int i = 0; i < exp_s.size() && s0 + i < samp_q.size(); i++)
            chk($sformatf("pause_samp%0d", i), 64'(samp_q[s0 + i]), 64'(exp_s[i]));

        // ---- reset while a read is stalled ----
        wait_cycles = 6;
        start_addr = 23'h10; end_addr = 23'h12; direction = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("prerst_read", 64'(bus.flash_read), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_read", 64'(bus.flash_read), 64'd0);
        chk("async_rst_valid", 64'(bus.sample_valid), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        wait_cycles = 0;
        run_range("after_rst", 23'h30, 23'h31, 1'b0, -1, a0, s0);

        // ---- looping instance: three passes over a two-word range ----
        startl = 1'b1;
        tick();
        startl = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (addr_ql.size() >= 7) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("loop_progress", 64'(ok), 64'd1);
        for (int i = 0; i < 7 && i < addr_ql.size(); i++)
            chk($sformatf("loop_addr%0d", i), 64'(addr_ql[i]), 64'(23'h50 + (i % 2)));
        chk("loop_no_done", 64'(done_l), 64'd0);
        chk("loop_busy", 64'(busyl), 64'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
